fc_layer_sequencer: RTL and testbench

// - Sequences one fully-connected layer through the 16-lane MAC neuron datapath (16 act x 16 weight + bias, truncated to 16b).
// - Splits IN_LEN inputs into CHUNKS=IN_LEN/16 chunks per neuron and issues activation/weight/bias memory reads.
// - Accumulates per-chunk ALU results with saturation and emits one result per neuron through a valid/ready port.
// - Sits between the layer top-level control, the act/weight/bias RAMs and the MAC datapath.

---
 rtl/fc_layer_sequencer.sv | 137 +++++++++++++
 tb/tb_fc_layer_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer
//   Sequences one fully-connected layer through the 16-lane MAC neuron
//   datapath. Each neuron's IN_LEN inputs are split into CHUNKS = IN_LEN/16
//   chunks. The block issues act/weight/bias RAM reads (read latency 1),
//   accumulates the per-chunk ALU results with 16-bit saturation, and presents
//   one result per neuron on a valid/ready port.
//
//   Optional feature: define RELU_EN to clamp negative results to 0 at the
//   output port. The accumulator itself is not altered.
//
// Ports
//   clk, rst       clock (rising edge) and synchronous active-high reset
//   start          begin a layer; sampled only in IDLE
//   busy           high in every state except IDLE
//   done           one-cycle pulse after the last neuron handshake
//   rd_en          read strobe to the act/weight/bias RAMs
//   act_addr       activation chunk index
//   w_addr         weight address = neuron*CHUNKS + chunk
//   b_addr         bias address = neuron index
//   alu_bias_en    gates the bias into the datapath during the chunk-0 data cycle
//   alu_result     signed datapath result for the chunk read in the previous cycle
//   out_valid      neuron result available
//   out_ready      consumer accepts the result
//   out_data       signed neuron result
//   out_addr       neuron index of out_data
module fc_layer_sequencer #(
    parameter int IN_LEN  = 64,
    parameter int OUT_LEN = 10,
    localparam int CHUNKS = IN_LEN / 16,
    localparam int AAW    = $clog2(CHUNKS),
    localparam int WAW    = $clog2(OUT_LEN * CHUNKS),
    localparam int OAW    = $clog2(OUT_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [AAW-1:0]    act_addr,
    output logic [WAW-1:0]    w_addr,
    output logic [OAW-1:0]    b_addr,
    output logic              alu_bias_en,
    input  logic [15:0]       alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [OAW-1:0]    out_addr
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] LAST = 3'd2;
    localparam logic [2:0] OUT  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]         state;
    logic [OAW-1:0]     neuron;
    logic [AAW-1:0]     chunk;
    logic signed [15:0] acc;
    logic               cap_vld;
    logic               bias_en;
    logic signed [16:0] sum;
    logic signed [15:0] acc_sat;
    logic signed [15:0] res;

    // 17-bit sum; the top two bits disagree only on overflow.
    always_comb begin
        sum = {acc[15], acc} + {alu_result[15], alu_result};
        case (sum[16:15])
            2'b01:   acc_sat = 16'sh7FFF;
            2'b10:   acc_sat = 16'sh8000;
            default: acc_sat = sum[15:0];
        endcase
    end

`ifdef RELU_EN
    always_comb res = acc[15] ? '0 : acc;
`else
    always_comb res = acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            neuron  <= '0;
            chunk   <= '0;
            acc     <= '0;
            cap_vld <= 1'b0;
            bias_en <= 1'b0;
        end else begin
            cap_vld <= rd_en;
            bias_en <= rd_en && (chunk == '0);
            if (cap_vld)
                acc <= acc_sat;
            case (state)
                IDLE: if (start) begin
                    state  <= LOAD;
                    neuron <= '0;
                    chunk  <= '0;
                    acc    <= '0;
                end
                LOAD: if (chunk == AAW'(CHUNKS - 1)) begin
                    chunk <= '0;
                    state <= LAST;
                end else begin
                    chunk <= chunk + 1'b1;
                end
                LAST: state <= OUT;
                OUT: if (out_ready) begin
                    if (neuron == OAW'(OUT_LEN - 1)) begin
                        state <= DONE;
                    end else begin
                        neuron <= neuron + 1'b1;
                        chunk  <= '0;
                        acc    <= '0;
                        state  <= LOAD;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign rd_en       = (state == LOAD);
    assign act_addr    = chunk;
    assign w_addr      = WAW'(int'(neuron) * CHUNKS + int'(chunk));
    assign b_addr      = neuron;
    assign alu_bias_en = bias_en;
    assign out_valid   = (state == OUT);
    assign out_data    = out_valid ? res : '0;
    assign out_addr    = out_valid ? neuron : '0;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
module tb_fc_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [1:0]  act_addr;
    logic [3:0]  w_addr;
    logic [1:0]  b_addr;
    logic        alu_bias_en;
    logic [15:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_addr;

    int checks = 0;
    int errors = 0;

    // Per-chunk ALU result, indexed by the activation chunk that was read.
    logic signed [15:0] tbl [4];
    logic               rd_q;
    logic [1:0]         aq;

    fc_layer_sequencer #(.IN_LEN(64), .OUT_LEN(3)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .act_addr(act_addr), .w_addr(w_addr), .b_addr(b_addr),
        .alu_bias_en(alu_bias_en), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    // RAM + ALU model: result for a read appears one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            rd_q <= 1'b0;
            aq   <= '0;
        end else begin
            rd_q <= rd_en;
            aq   <= act_addr;
        end
    end
    assign alu_result = rd_q ? tbl[aq] : 16'h0000;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_tbl(input int a, input int b, input int c, input int d);
        tbl[0] = 16'(a); tbl[1] = 16'(b); tbl[2] = 16'(c); tbl[3] = 16'(d);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_act_addr"}, act_addr, 0);
        chk({tag, "_w_addr"}, w_addr, 0);
        chk({tag, "_b_addr"}, b_addr, 0);
        chk({tag, "_bias_en"}, alu_bias_en, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_addr"}, out_addr, 0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        chk({tag, "_valid_timeout"}, out_valid, 1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        chk({tag, "_done_timeout"}, done, 1);
    endtask

    // Full layer with out_ready high; every neuron must produce exp_out.
    task automatic run_layer(input string tag, input int exp_out);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            wait_valid(tag);
            chk({tag, "_out_data"}, $signed(out_data), exp_out);
            chk({tag, "_out_addr"}, out_addr, n);
            @(negedge clk);
        end
        chk({tag, "_done"}, done, 1);
        @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int n, p, bias_cnt;
        logic [15:0] hold_data;

        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        set_tbl(100, 100, 100, 100);
        @(negedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Basic flow: cycle k after the start cycle, neuron n, phase p.
        start = 1'b1;
        bias_cnt = 0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            start = 1'b0;
            n = (k - 1) / 6;
            p = (k - 1) % 6;
            if (alu_bias_en) bias_cnt++;
            chk("basic_busy", busy, 1);
            chk("basic_done", done, (k == 19) ? 1 : 0);
            chk("basic_rd_en", rd_en, (k < 19 && p < 4) ? 1 : 0);
            chk("basic_bias_en", alu_bias_en, (k < 19 && p == 1) ? 1 : 0);
            chk("basic_out_valid", out_valid, (k < 19 && p == 5) ? 1 : 0);
            if (k < 19 && p < 4) begin
                chk("basic_act_addr", act_addr, p);
                chk("basic_w_addr", w_addr, n * 4 + p);
                chk("basic_b_addr", b_addr, n);
            end
            if (k < 19 && p == 5) begin
                chk("basic_out_data", $signed(out_data), 400);
                chk("basic_out_addr", out_addr, n);
            end
        end
        chk("basic_bias_pulses", bias_cnt, 3);
        @(negedge clk);
        chk("basic_idle", busy, 0);
        chk("basic_done_pulse", done, 0);

        // Saturation in both directions.
        set_tbl(20000, 20000, 20000, 20000);
        run_layer("sat_pos", 32767);
        set_tbl(-20000, -20000, -20000, -20000);
        run_layer("sat_neg", -32768);

        // Backpressure on the first neuron.
        set_tbl(100, 100, 100, 100);
        out_ready = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_valid("bp");
        hold_data = out_data;
        chk("bp_first_data", $signed(out_data), 400);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, hold_data);
            chk("bp_addr", out_addr, 0);
            chk("bp_rd_en", rd_en, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_rd", rd_en, 1);
        chk("bp_resume_waddr", w_addr, 4);
        wait_done("bp");
        @(negedge clk);

        // Start while busy is ignored; reset mid-LOAD aborts.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("sb_waddr0", w_addr, 0);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("sb_waddr1", w_addr, 1);
        @(negedge clk);
        chk("sb_waddr2", w_addr, 2);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_zero_outputs("midrst");
        bias_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) bias_cnt++;
        end
        chk("midrst_no_done", bias_cnt, 0);
        chk("midrst_idle", busy, 0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("restart_rd", rd_en, 1);
        chk("restart_waddr", w_addr, 0);
        wait_done("restart");
        @(negedge clk);

        // Negative result: ReLU clamps it, otherwise it passes through.
        set_tbl(-20, -10, -10, -10);
`ifdef RELU_EN
        run_layer("relu", 0);
`else
        run_layer("relu", -50);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
